// File: rtl/id_exe_stage_pkg.sv
// Shared pipeline definitions: default field widths, the zero-register constant
// and the control-field bundle carried between stage registers.
package id_exe_stage_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int RADDR_W_DEF = 5;
   localparam int WB_W_DEF    = 2;
   localparam int M_W_DEF     = 2;
   localparam int EX_W_DEF    = 5;
   localparam int CNT_W_DEF   = 16;

   // Register 0 is hard-wired to zero, so writes to it never forward.
   localparam int ZERO_REG = 0;

   typedef struct packed {
      logic [WB_W_DEF-1:0] wb;
      logic [M_W_DEF-1:0]  m;
      logic [EX_W_DEF-1:0] ex;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_wt_sel.sv
// Register-file write-through select for one read operand: a same-cycle
// write to the operand's source register replaces the stale read value.
module idexe_wt_sel
   import id_exe_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RADDR_W = RADDR_W_DEF
) (
   input  logic [DATA_W-1:0]  rdata,
   input  logic [RADDR_W-1:0] raddr,
   input  logic               we,
   input  logic [RADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  sel
);

   logic hit;

   assign hit = we && (waddr != RADDR_W'(ZERO_REG)) && (waddr == raddr);
   assign sel = hit ? wdata : rdata;

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with flush (bubble), stall (hold), register-file
// write-through on the read operands and a saturating stalled-cycle counter.
module id_exe_stage
   import id_exe_stage_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RADDR_W = RADDR_W_DEF,
   parameter int WB_W    = WB_W_DEF,
   parameter int M_W     = M_W_DEF,
   parameter int EX_W    = EX_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               Stall,
   input  logic               Flush,
   input  logic               IdValid,
   input  logic [WB_W-1:0]    IdWb,
   input  logic [M_W-1:0]     IdM,
   input  logic [EX_W-1:0]    IdEx,
   input  logic [DATA_W-1:0]  IdReadD1,
   input  logic [DATA_W-1:0]  IdReadD2,
   input  logic [DATA_W-1:0]  IdAdr,
   input  logic [RADDR_W-1:0] IdRs,
   input  logic [RADDR_W-1:0] IdRt,
   input  logic [RADDR_W-1:0] IdRd,
   input  logic               WbWe,
   input  logic [RADDR_W-1:0] WbAddr,
   input  logic [DATA_W-1:0]  WbData,
   output logic               ExValid,
   output logic [WB_W-1:0]    ExWb,
   output logic [M_W-1:0]     ExM,
   output logic [EX_W-1:0]    ExEx,
   output logic [DATA_W-1:0]  ExReadD1,
   output logic [DATA_W-1:0]  ExReadD2,
   output logic [DATA_W-1:0]  ExAdr,
   output logic [RADDR_W-1:0] ExRs,
   output logic [RADDR_W-1:0] ExRt,
   output logic [RADDR_W-1:0] ExRd,
   output logic [CNT_W-1:0]   StallCnt
);

   logic [DATA_W-1:0] rd1_sel;
   logic [DATA_W-1:0] rd2_sel;

   idexe_wt_sel #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_wt_rs (
      .rdata (IdReadD1),
      .raddr (IdRs),
      .we    (WbWe),
      .waddr (WbAddr),
      .wdata (WbData),
      .sel   (rd1_sel)
   );

   idexe_wt_sel #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_wt_rt (
      .rdata (IdReadD2),
      .raddr (IdRt),
      .we    (WbWe),
      .waddr (WbAddr),
      .wdata (WbData),
      .sel   (rd2_sel)
   );

   // Priority: reset, then flush (bubble, counter untouched), then stall, then load.
   always_ff @(posedge clk) begin
      if (rst || Flush) begin
         ExValid  <= 1'b0;
         ExWb     <= '0;
         ExM      <= '0;
         ExEx     <= '0;
         ExReadD1 <= '0;
         ExReadD2 <= '0;
         ExAdr    <= '0;
         ExRs     <= '0;
         ExRt     <= '0;
         ExRd     <= '0;
         if (rst) StallCnt <= '0;
      end else if (Stall) begin
         if (StallCnt != '1) StallCnt <= StallCnt + CNT_W'(1);
      end else begin
         ExValid  <= IdValid;
         ExWb     <= IdValid ? IdWb : '0;
         ExM      <= IdValid ? IdM  : '0;
         ExEx     <= IdValid ? IdEx : '0;
         ExReadD1 <= rd1_sel;
         ExReadD2 <= rd2_sel;
         ExAdr    <= IdAdr;
         ExRs     <= IdRs;
         ExRt     <= IdRt;
         ExRd     <= IdRd;
      end
   end

endmodule

// File: doc/id_exe_stage.md
ID_EXE_STAGE -- requirements
Module: id_exe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning width of operand and immediate fields.
REQ-002 The block SHALL have parameter RADDR_W, default 5, meaning register-address width.
REQ-003 The block SHALL have parameters WB_W, M_W and EX_W, defaults 2, 2 and 5, meaning control-field widths.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 Stall  in  1  hold current contents.
REQ-008 Flush  in  1  load a bubble.
REQ-009 IdValid  in  1  ID stage holds a real instruction.
REQ-010 IdWb/IdM/IdEx  in  WB_W/M_W/EX_W  control fields from decode.
REQ-011 IdReadD1, IdReadD2, IdAdr  in  DATA_W  operands and sign-extended immediate.
REQ-012 IdRs, IdRt, IdRd  in  RADDR_W  register specifiers.
REQ-013 WbWe  in  1, WbAddr  in  RADDR_W, WbData  in  DATA_W  same-cycle register-file write port snoop.
REQ-014 ExValid, ExWb, ExM, ExEx, ExReadD1, ExReadD2, ExAdr, ExRs, ExRt, ExRd  out  widths matching inputs  registered stage outputs.
REQ-015 StallCnt  out  CNT_W  count of stalled cycles.

Function
REQ-016 Update priority per edge SHALL be: rst, then Flush, then Stall, then load.
REQ-017 Load (no rst, Flush=0, Stall=0) SHALL capture all Id* inputs into Ex* outputs with one-cycle latency; ExValid SHALL take IdValid.
REQ-018 On load, ExReadD1 SHALL take WbData when WbWe=1, WbAddr!=0 and WbAddr==IdRs, else IdReadD1.
REQ-019 On load, ExReadD2 SHALL take WbData when WbWe=1, WbAddr!=0 and WbAddr==IdRt, else IdReadD2.
REQ-020 A write with WbAddr=0 SHALL never be forwarded.
REQ-021 When IdValid=0 on load, all control fields (ExWb, ExM, ExEx) SHALL load zero; data fields load normally.
REQ-022 Flush SHALL set ExValid, ExWb, ExM, ExEx to zero; data and specifier fields SHALL be zeroed.
REQ-023 Flush and Stall asserted together SHALL produce a bubble (flush wins).
REQ-024 Stall=1, Flush=0 SHALL hold every Ex* output unchanged, with no write-through applied to held data.
REQ-025 StallCnt SHALL increment by one on each edge with Stall=1, Flush=0, rst=0.
REQ-026 StallCnt SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-027 Outputs SHALL be driven only from registers; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 at a rising edge SHALL zero every Ex* output, ExValid and StallCnt, regardless of Stall or Flush.
REQ-029 rst asserted mid-stall SHALL discard the held entry; the first edge after rst deasserts SHALL behave as a normal load.

Structure
REQ-030 Default widths, the zero-register constant and the control-field bundle typedef SHALL live in the shared pipeline package, used by all stage registers.
REQ-031 Write-through selection SHALL be one sub-module, idexe_wt_sel, instantiated once per read operand.

Verification
REQ-032 Load IdReadD1=0x11, IdRs=3, IdWb=2'b11, IdValid=1, no WB write -> next cycle ExReadD1=0x11, ExWb=2'b11, ExValid=1.
REQ-033 IdRs=5, IdRt=5, WbWe=1, WbAddr=5, WbData=0xABCD -> ExReadD1=ExReadD2=0xABCD; repeat with WbAddr=0 -> original IdReadD1/D2 captured.
REQ-034 Stall for 3 cycles while inputs change -> Ex* unchanged for 3 cycles, StallCnt=3; Stall and Flush together -> ExValid=0, ExWb=ExM=ExEx=0, StallCnt unchanged.
REQ-035 CNT_W=4, Stall held 20 cycles -> StallCnt reaches 15 and stays 15.
REQ-036 rst during stall with ExValid=1 -> all outputs 0 next edge; after release, load of IdValid=1 gives ExValid=1 next cycle.
